// File: rtl/adc_burst_pkg.sv
// Shared constants, state encoding and header assembly for the ADC burst assembler.
package adc_burst_pkg;

    // Word tags carried in out_dat[131:128]
    localparam logic [3:0] TAG_FILL = 4'd1;
    localparam logic [3:0] TAG_WFM  = 4'd2;
    localparam logic [3:0] TAG_DATA = 4'd3;
    localparam logic [3:0] TAG_CSUM = 4'd4;

    // Marker in the top two payload bits of every header
    localparam logic [1:0] HDR_MARK = 2'b01;

    // Width of the word and waveform counters (wrap modulo 2^23)
    localparam int CNT_W = 23;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ARMED    = 3'd1;
    localparam state_t ST_WFM_HDR  = 3'd2;
    localparam state_t ST_DATA     = 3'd3;
    localparam state_t ST_FILL_HDR = 3'd4;
    localparam state_t ST_CSUM     = 3'd5;

    // Waveform header payload; start_addr is already word_count*2
    function automatic logic [127:0] wfm_hdr(
        input logic [13:0]      num_bursts,
        input logic [11:0]      pre_trig_hi,
        input logic [CNT_W-1:0] start_addr,
        input logic [CNT_W-1:0] wfm_idx,
        input logic [41:0]      trig_time,
        input logic [11:0]      chan
    );
        wfm_hdr = {HDR_MARK, trig_time[41:26], chan, trig_time[25:0],
                   wfm_idx, start_addr, pre_trig_hi, num_bursts};
    endfunction

    // Fill header payload; total_words includes this header and the checksum
    function automatic logic [127:0] fill_hdr(
        input logic [23:0]      fill_no,
        input logic [1:0]       range,
        input logic [CNT_W-1:0] total_words,
        input logic [13:0]      num_bursts,
        input logic [15:0]      pre_trig,
        input logic [CNT_W-1:0] wfm_total,
        input logic [11:0]      chan
    );
        fill_hdr = {HDR_MARK, 2'b00, 1'b1, 1'b0, chan, 7'd0, pre_trig[15:12],
                    wfm_total, pre_trig[11:0], num_bursts, total_words,
                    1'b0, range, fill_no};
    endfunction

endpackage

// File: rtl/adc_burst_assembler_packer.sv
// Combinational lane packer: drops each sample's over-range LSB, sign-extends
// the ADC value into its output lane and zero-pads unused payload bits.
module adc_sample_packer
    import adc_burst_pkg::*;
#(
    parameter int SAMPLES_PER_BURST = 8,
    parameter int ADC_W             = 12,
    parameter int LANE_W            = 128 / SAMPLES_PER_BURST
) (
    input  logic [SAMPLES_PER_BURST*(ADC_W+1)-1:0] adc_dat,
    output logic [127:0]                           payload
);

    if (!(SAMPLES_PER_BURST == 8 || SAMPLES_PER_BURST == 10)) begin : g_bad_spb
        $error("SAMPLES_PER_BURST must be 8 or 10");
    end
    if (LANE_W < ADC_W) begin : g_bad_lane
        $error("LANE_W must be at least ADC_W");
    end
    if (SAMPLES_PER_BURST * LANE_W > 128) begin : g_bad_fit
        $error("lanes do not fit in a 128-bit payload");
    end

    logic [SAMPLES_PER_BURST-1:0] over_range;
    logic                         unused_over_range;

    for (genvar i = 0; i < SAMPLES_PER_BURST; i++) begin : g_lane
        logic [ADC_W-1:0] sample;
        assign sample     = adc_dat[i*(ADC_W+1)+1 +: ADC_W];
        assign over_range[i] = adc_dat[i*(ADC_W+1)];
        assign payload[i*LANE_W +: LANE_W] = LANE_W'($signed(sample));
    end

    if (SAMPLES_PER_BURST * LANE_W < 128) begin : g_pad
        assign payload[127:SAMPLES_PER_BURST*LANE_W] = '0;
    end

    // Over-range flags are not carried in the output stream
    assign unused_over_range = ^over_range;

endmodule

// File: rtl/adc_burst_assembler.sv
// Fill stream builder: waveform headers, ADC data bursts, fill header, checksum.
// Handshakes: a transfer happens on a rising edge where valid && ready; a source
// holds valid and data stable until that edge, ready may depend on valid.
module adc_burst_assembler
    import adc_burst_pkg::*;
#(
    parameter int SAMPLES_PER_BURST = 8,
    parameter int ADC_W             = 12,
    parameter int LANE_W            = 128 / SAMPLES_PER_BURST
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   fill_start,
    input  logic                                   fill_end,
    input  logic                                   trig,
    input  logic [41:0]                            trigger_time,
    input  logic                                   adc_valid,
    output logic                                   adc_ready,
    input  logic [SAMPLES_PER_BURST*(ADC_W+1)-1:0] adc_dat,
    input  logic [23:0]                            fill_num,
    input  logic [11:0]                            channel_tag,
    input  logic [1:0]                             ddr3_range,
    input  logic [13:0]                            wfm_num_bursts,
    input  logic [15:0]                            wfm_pre_trig,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [131:0]                           out_dat,
    output logic                                   busy,
    output logic                                   trig_dropped,
    output logic [2:0]                             dbg_state
);

    state_t             state;
    logic [23:0]        cfg_fill_num;
    logic [11:0]        cfg_chan;
    logic [1:0]         cfg_range;
    logic [13:0]        cfg_nb;
    logic [15:0]        cfg_pre;
    logic [41:0]        trig_time_q;
    logic [CNT_W-1:0]   wfm_count;
    logic [CNT_W-1:0]   word_count;
    logic [127:0]       checksum;
    logic [13:0]        burst_cnt;
    logic               fe_pend;

    logic               slot_free;
    logic               load;
    logic [131:0]       next_word;
    logic [127:0]       data_payload;
    logic               fill_arm;
    logic               last_burst;

    adc_sample_packer #(
        .SAMPLES_PER_BURST (SAMPLES_PER_BURST),
        .ADC_W             (ADC_W),
        .LANE_W            (LANE_W)
    ) u_packer (
        .adc_dat (adc_dat),
        .payload (data_payload)
    );

    assign dbg_state  = state;
    assign busy       = (state != ST_IDLE);
    assign slot_free  = !out_valid || out_ready;
    assign adc_ready  = (state == ST_DATA) && slot_free;
    assign fill_arm   = (state == ST_IDLE) && fill_start;
    assign last_burst = (burst_cnt == cfg_nb - 14'd1);

    // Select the word the current state offers to the output register
    always_comb begin
        load      = 1'b0;
        next_word = '0;
        case (state)
            ST_WFM_HDR: begin
                load      = slot_free;
                next_word = {TAG_WFM, wfm_hdr(cfg_nb, cfg_pre[13:2],
                             {word_count[CNT_W-2:0], 1'b0}, wfm_count,
                             trig_time_q, cfg_chan)};
            end
            ST_DATA: begin
                load      = adc_valid && slot_free;
                next_word = {TAG_DATA, data_payload};
            end
            ST_FILL_HDR: begin
                load      = slot_free;
                next_word = {TAG_FILL, fill_hdr(cfg_fill_num, cfg_range,
                             word_count + 23'd2, cfg_nb, cfg_pre, wfm_count,
                             cfg_chan)};
            end
            ST_CSUM: begin
                load      = slot_free;
                next_word = {TAG_CSUM, checksum};
            end
            default: begin
                load      = 1'b0;
                next_word = '0;
            end
        endcase
    end

    // Fill sequencing, configuration latch and waveform/burst counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cfg_fill_num <= '0;
            cfg_chan     <= '0;
            cfg_range    <= '0;
            cfg_nb       <= '0;
            cfg_pre      <= '0;
            trig_time_q  <= '0;
            wfm_count    <= '0;
            burst_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        state        <= ST_ARMED;
                        cfg_fill_num <= fill_num;
                        cfg_chan     <= channel_tag;
                        cfg_range    <= ddr3_range;
                        cfg_nb       <= wfm_num_bursts;
                        cfg_pre      <= wfm_pre_trig;
                        wfm_count    <= '0;
                    end
                end
                ST_ARMED: begin
                    if (fill_end) begin
                        state <= ST_FILL_HDR;
                    end else if (trig) begin
                        state       <= ST_WFM_HDR;
                        trig_time_q <= trigger_time;
                    end
                end
                ST_WFM_HDR: begin
                    if (load) begin
                        state     <= ST_DATA;
                        burst_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (load) begin
                        if (last_burst) begin
                            burst_cnt <= '0;
                            wfm_count <= wfm_count + 23'd1;
                            state     <= (fe_pend || fill_end) ? ST_FILL_HDR : ST_ARMED;
                        end else begin
                            burst_cnt <= burst_cnt + 14'd1;
                        end
                    end
                end
                ST_FILL_HDR: begin
                    if (load) state <= ST_CSUM;
                end
                ST_CSUM: begin
                    if (load) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky trigger-drop flag and the fill_end seen while a waveform is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_dropped <= 1'b0;
            fe_pend      <= 1'b0;
        end else if (fill_arm) begin
            trig_dropped <= 1'b0;
            fe_pend      <= 1'b0;
        end else begin
            if (trig && ((state == ST_ARMED && fill_end) || state == ST_WFM_HDR ||
                         state == ST_DATA || state == ST_FILL_HDR || state == ST_CSUM))
                trig_dropped <= 1'b1;
            if (fill_end && (state == ST_WFM_HDR || state == ST_DATA))
                fe_pend <= 1'b1;
        end
    end

    // Output register, word counter and running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_dat    <= '0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_dat   <= next_word;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (fill_arm) begin
                word_count <= '0;
                checksum   <= '0;
            end else if (load) begin
                word_count <= word_count + 23'd1;
                if (state != ST_CSUM) checksum <= checksum ^ next_word[127:0];
            end
        end
    end

endmodule

// File: tb/tb_adc_burst_assembler.sv
// Bench for adc_burst_assembler: directed fills, a stream model with an
// expected-word queue, and literal pins on selected header/data fields.
module tb_adc_burst_assembler;

    localparam int DW   = 8 * 13;
    localparam int DW10 = 10 * 13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, fill_start, fill_end, trig;
    logic [41:0]   trigger_time;
    logic          adc_valid, adc_ready;
    logic [DW-1:0] adc_dat;
    logic [23:0]   fill_num;
    logic [11:0]   channel_tag;
    logic [1:0]    ddr3_range;
    logic [13:0]   wfm_num_bursts;
    logic [15:0]   wfm_pre_trig;
    logic          out_valid, out_ready;
    logic [131:0]  out_dat;
    logic          busy, trig_dropped;
    logic [2:0]    dbg_state;

    logic            adc_valid10, adc_ready10, out_valid10, out_ready10;
    logic [DW10-1:0] adc_dat10;
    logic [131:0]    out_dat10;
    logic            busy10, trig_dropped10;
    logic [2:0]      dbg_state10;

    adc_burst_assembler dut (
        .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_end(fill_end),
        .trig(trig), .trigger_time(trigger_time), .adc_valid(adc_valid),
        .adc_ready(adc_ready), .adc_dat(adc_dat), .fill_num(fill_num),
        .channel_tag(channel_tag), .ddr3_range(ddr3_range),
        .wfm_num_bursts(wfm_num_bursts), .wfm_pre_trig(wfm_pre_trig),
        .out_valid(out_valid), .out_ready(out_ready), .out_dat(out_dat),
        .busy(busy), .trig_dropped(trig_dropped), .dbg_state(dbg_state)
    );

    adc_burst_assembler #(.SAMPLES_PER_BURST(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_end(fill_end),
        .trig(trig), .trigger_time(trigger_time), .adc_valid(adc_valid10),
        .adc_ready(adc_ready10), .adc_dat(adc_dat10), .fill_num(fill_num),
        .channel_tag(channel_tag), .ddr3_range(ddr3_range),
        .wfm_num_bursts(wfm_num_bursts), .wfm_pre_trig(wfm_pre_trig),
        .out_valid(out_valid10), .out_ready(out_ready10), .out_dat(out_dat10),
        .busy(busy10), .trig_dropped(trig_dropped10), .dbg_state(dbg_state10)
    );

    // ---------------- scoreboard ----------------
    logic [131:0] exp_q[$];
    logic [131:0] got_q[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: got timeout/extra expected event", name);
    endtask

    function automatic logic [131:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 'x;
    endfunction

    // ---------------- model ----------------
    logic [23:0]  m_fill;
    logic [11:0]  m_chan;
    logic [1:0]   m_range;
    logic [13:0]  m_nb;
    logic [15:0]  m_pre;
    int           m_wc, m_wfm;
    logic [127:0] m_csum;
    logic [127:0] exp10;

    function automatic logic [127:0] pack8(input logic [DW-1:0] d);
        logic [127:0] p;
        logic [11:0]  s;
        p = '0;
        for (int j = 0; j < 8; j++) begin
            s = d[j*13+1 +: 12];
            p[j*16 +: 16] = {{4{s[11]}}, s};
        end
        return p;
    endfunction

    function automatic logic [DW-1:0] mk_dat(input int mode, input int k);
        logic [DW-1:0] d;
        logic [11:0]   v;
        for (int j = 0; j < 8; j++) begin
            if (mode == 0) d[j*13 +: 13] = {12'h7FF, 1'b0};
            else if (mode == 1) d[j*13 +: 13] = (j == 0) ? {12'h800, 1'b1} : {12'h123, 1'b0};
            else begin
                v = 12'((k * 8 + j) * 165 + 960);
                d[j*13 +: 13] = {v, 1'(j % 2)};
            end
        end
        return d;
    endfunction

    function automatic logic [127:0] m_wfm_hdr(input logic [41:0] t);
        logic [127:0] p;
        p = '0;
        p[13:0]    = m_nb;
        p[25:14]   = m_pre[13:2];
        p[48:26]   = 23'(m_wc * 2);
        p[71:49]   = 23'(m_wfm);
        p[97:72]   = t[25:0];
        p[109:98]  = m_chan;
        p[125:110] = t[41:26];
        p[127:126] = 2'b01;
        return p;
    endfunction

    function automatic logic [127:0] m_fill_hdr();
        logic [127:0] p;
        p = '0;
        p[23:0]    = m_fill;
        p[25:24]   = m_range;
        p[49:27]   = 23'(m_wc + 2);
        p[63:50]   = m_nb;
        p[75:64]   = m_pre[11:0];
        p[98:76]   = 23'(m_wfm);
        p[102:99]  = m_pre[15:12];
        p[121:110] = m_chan;
        p[123]     = 1'b1;
        p[127:126] = 2'b01;
        return p;
    endfunction

    task automatic push_word(input logic [3:0] tag, input logic [127:0] p);
        exp_q.push_back({tag, p});
        if (tag != 4'd4) m_csum ^= p;
        m_wc++;
    endtask

    task automatic push_fill();
        push_word(4'd1, m_fill_hdr());
        push_word(4'd4, m_csum);
    endtask

    // ---------------- compare process ----------------
    logic         stall_prev = 1'b0;
    logic [131:0] dat_prev;
    int           n10 = 0;
    logic [131:0] last10;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_dat", out_dat, dat_prev);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_dat);
                if (exp_q.size() == 0) fail_now("unexpected_word");
                else check("stream", out_dat, exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            dat_prev   = out_dat;
            if (out_valid10 && out_dat10[131:128] == 4'd3) begin
                check("dut10_data", out_dat10, {4'd3, exp10});
                last10 = out_dat10;
                n10++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fill_start();
        m_fill = fill_num; m_chan = channel_tag; m_range = ddr3_range;
        m_nb = wfm_num_bursts; m_pre = wfm_pre_trig;
        m_wc = 0; m_wfm = 0; m_csum = '0;
        fill_start = 1'b1;
        cycle(1);
        fill_start = 1'b0;
    endtask

    task automatic start_wfm(input logic [41:0] t);
        trigger_time = t;
        trig = 1'b1;
        push_word(4'd2, m_wfm_hdr(t));
        cycle(1);
        trig = 1'b0;
    endtask

    task automatic pulse_trig_only();
        trig = 1'b1;
        cycle(1);
        trig = 1'b0;
    endtask

    task automatic pulse_fe_only();
        fill_end = 1'b1;
        cycle(1);
        fill_end = 1'b0;
    endtask

    task automatic end_fill();
        fill_end = 1'b1;
        push_fill();
        cycle(1);
        fill_end = 1'b0;
    endtask

    task automatic send_burst(input logic [DW-1:0] d);
        bit hs;
        int n;
        hs = 0;
        n  = 0;
        adc_dat   = d;
        adc_valid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = adc_ready;
            @(posedge clk);
            #1;
            n++;
        end
        adc_valid = 1'b0;
        if (!hs) fail_now("adc_handshake");
        else push_word(4'd3, pack8(d));
    endtask

    task automatic stall5();
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_adc_ready", adc_ready, 0);
            check("stall_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic do_waveform(input logic [41:0] t, input int nb, input int mode,
                               input int trig_at, input int fe_at, input int stall_at);
        start_wfm(t);
        for (int k = 0; k < nb; k++) begin
            if (k == trig_at) pulse_trig_only();
            if (k == fe_at) pulse_fe_only();
            if (k == stall_at) begin
                adc_dat   = mk_dat(mode, k);
                adc_valid = 1'b1;
                stall5();
            end
            send_burst(mk_dat(mode, k));
        end
        m_wfm++;
        if (fe_at >= 0) push_fill();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cycle(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    int g0;

    initial begin
        rst_n = 1'b0; fill_start = 1'b0; fill_end = 1'b0; trig = 1'b0;
        trigger_time = '0; adc_valid = 1'b0; adc_dat = '0;
        fill_num = '0; channel_tag = '0; ddr3_range = '0;
        wfm_num_bursts = 14'd1; wfm_pre_trig = '0; out_ready = 1'b1;
        adc_valid10 = 1'b1; out_ready10 = 1'b1;
        exp10 = '0;
        for (int i = 0; i < 10; i++) begin
            logic [11:0] v;
            v = (i == 0) ? 12'h800 : 12'(i * 12'h155);
            adc_dat10[i*13 +: 13] = {v, 1'b1};
            exp10[i*12 +: 12] = v;
        end

        // reset state
        cycle(3);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_dat", out_dat, 0);
        check("rst_adc_ready", adc_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_trig_dropped", trig_dropped, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(2);

        // one waveform of 2 bursts at 0x7FF, then fill_end
        fill_num = 24'hABCDE1; channel_tag = 12'h5A3; ddr3_range = 2'd2;
        wfm_num_bursts = 14'd2; wfm_pre_trig = 16'hBEEF;
        g0 = got_q.size();
        pulse_fill_start();
        fill_num = 24'h000000;
        check("busy_armed", busy, 1);
        do_waveform(42'h2AB_CDEF_0123, 2, 0, -1, -1, -1);
        end_fill();
        drain("drain_t1");
        check("busy_idle", busy, 0);
        check("t1_tag0", got_at(g0)[131:128], 2);
        check("t1_tag1", got_at(g0+1)[131:128], 3);
        check("t1_tag2", got_at(g0+2)[131:128], 3);
        check("t1_tag3", got_at(g0+3)[131:128], 1);
        check("t1_tag4", got_at(g0+4)[131:128], 4);
        check("t1_lane0", got_at(g0+1)[15:0], 16'h07FF);
        check("t1_lane7", got_at(g0+2)[127:112], 16'h07FF);
        check("t1_total_words", got_at(g0+3)[49:27], 5);
        check("t1_wfm_count", got_at(g0+3)[98:76], 1);
        check("t1_fill_num", got_at(g0+3)[23:0], 24'hABCDE1);
        check("t1_csum", got_at(g0+4)[127:0],
              got_at(g0)[127:0] ^ got_at(g0+1)[127:0] ^ got_at(g0+2)[127:0] ^ got_at(g0+3)[127:0]);

        // three single-burst waveforms
        wfm_num_bursts = 14'd1; fill_num = 24'h000102;
        g0 = got_q.size();
        pulse_fill_start();
        do_waveform(42'h000_0000_0010, 1, 2, -1, -1, -1);
        do_waveform(42'h000_0000_0020, 1, 2, -1, -1, -1);
        do_waveform(42'h3FF_FFFF_FFFF, 1, 2, -1, -1, -1);
        end_fill();
        drain("drain_t2");
        check("t2_addr0", got_at(g0)[48:26], 0);
        check("t2_addr1", got_at(g0+2)[48:26], 4);
        check("t2_addr2", got_at(g0+4)[48:26], 8);
        check("t2_idx0", got_at(g0)[71:49], 0);
        check("t2_idx1", got_at(g0+2)[71:49], 1);
        check("t2_idx2", got_at(g0+4)[71:49], 2);
        check("t2_total_words", got_at(g0+6)[49:27], 8);

        // over-range sample, stall, dropped trigger, fill_end during DATA
        wfm_num_bursts = 14'd6; wfm_pre_trig = 16'h1234;
        g0 = got_q.size();
        pulse_fill_start();
        do_waveform(42'h155_5555_5555, 6, 1, 2, -1, 3);
        check("t3_trig_dropped", trig_dropped, 1);
        do_waveform(42'h0AA_AAAA_AAAA, 6, 2, -1, 4, -1);
        drain("drain_t3");
        check("t3_lane_neg", got_at(g0+1)[15:0], 16'hF800);
        check("t3_lane1", got_at(g0+1)[31:16], 16'h0123);
        check("t3_hdr2_idx", got_at(g0+7)[71:49], 1);
        check("t3_hdr2_addr", got_at(g0+7)[48:26], 14);
        check("t3_fill_tag", got_at(g0+14)[131:128], 1);
        check("t3_fill_wfm", got_at(g0+14)[98:76], 2);
        check("t3_csum_tag", got_at(g0+15)[131:128], 4);

        // trig and fill_end together while ARMED
        g0 = got_q.size();
        pulse_fill_start();
        check("t4_dropped_cleared", trig_dropped, 0);
        trig = 1'b1;
        end_fill();
        trig = 1'b0;
        drain("drain_t4");
        check("t4_trig_dropped", trig_dropped, 1);
        check("t4_fill_tag", got_at(g0)[131:128], 1);
        check("t4_total_words", got_at(g0)[49:27], 2);
        check("t4_fill_bit123", got_at(g0)[123], 1);

        // reset mid-DATA, then a fresh fill
        wfm_num_bursts = 14'd4;
        pulse_fill_start();
        start_wfm(42'h012_3456_789A);
        send_burst(mk_dat(2, 0));
        pulse_trig_only();
        send_burst(mk_dat(2, 1));
        check("t5_trig_dropped", trig_dropped, 1);
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_out_dat", out_dat, 0);
        check("t5_adc_ready", adc_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_trig_dropped_rst", trig_dropped, 0);
        exp_q.delete();
        cycle(2);
        rst_n = 1'b1;
        cycle(1);
        g0 = got_q.size();
        pulse_fill_start();
        do_waveform(42'h001_0000_0001, 4, 2, -1, -1, -1);
        end_fill();
        drain("drain_t5");
        check("t5_wfm_idx", got_at(g0)[71:49], 0);
        check("t5_addr", got_at(g0)[48:26], 0);

        // 10-sample instance pins
        check("dut10_seen", n10 > 0, 1);
        check("dut10_lane0", last10[11:0], 12'h800);
        check("dut10_pad", last10[127:120], 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_burst_assembler.md
# adc_burst_assembler

Parametrised successor to the self-triggered ADC data mux. It builds and emits the complete 132-bit word stream for one fill: waveform headers, ADC data bursts, then a fill header carrying final counts, then a checksum. Its own FSM sequences the stream, and valid/ready handshakes run on both the ADC side and the DDR3 write-FIFO side. It sits between the ADC deserialiser/trigger logic and the DDR3 write FIFO.

## Interface
- SAMPLES_PER_BURST, 8, samples per data word; legal values are 8 or 10.
- ADC_W, 12, ADC sample width; each input sample carries 1 extra over-range LSB.
- LANE_W, 128/SAMPLES_PER_BURST, output lane per sample; 16 for 8 samples, 12 for 10 samples.
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- fill_start  in  1  pulse; arms a new fill.
- fill_end  in  1  pulse; closes the fill.
- trig  in  1  trigger pulse.
- trigger_time  in  42  time tag, sampled with trig.
- adc_valid / adc_ready  in/out  1/1  ADC burst handshake.
- adc_dat  in  SAMPLES_PER_BURST*(ADC_W+1)  packed samples; sample 0 is oldest, at the LSBs.
- fill_num  in  24  fill number.
- channel_tag  in  12  channel tag.
- ddr3_range  in  2  fill type.
- wfm_num_bursts  in  14  data words per waveform; must be ≥1.
- wfm_pre_trig  in  16  pre-trigger ADC pairs.
- out_valid / out_ready  out/in  1/1  FIFO handshake.
- out_dat  out  132  {4-bit tag, 128-bit payload}.
- busy  out  1  high when not IDLE.
- trig_dropped  out  1  sticky; cleared by fill_start.

## Operation
- The FSM has six states: IDLE, ARMED, WFM_HDR, DATA, FILL_HDR, CSUM.
- IDLE:
  - fill_start → ARMED.
  - On entry to ARMED, latch fill_num, channel_tag, ddr3_range, wfm_num_bursts and wfm_pre_trig.
  - Zero wfm_count, word_count, checksum and trig_dropped.
  - trig and fill_end are ignored in IDLE.
- ARMED:
  - trig → WFM_HDR; latch trigger_time.
  - fill_end → FILL_HDR.
  - If both arrive in the same cycle, fill_end wins and the trigger is dropped. This sets trig_dropped.
- WFM_HDR:
  - Emit one waveform header, then → DATA with burst_cnt=0.
  - Waveform header, tag 2, bits:
    - [13:0] wfm_num_bursts
    - [25:14] pre_trig[13:2]
    - [48:26] start address = word_count×2, with word_count taken at this header
    - [71:49] wfm_count
    - [97:72] time[25:0]
    - [109:98] channel_tag
    - [125:110] time[41:26]
    - [127:126] = 2'b01
- DATA:
  - Each adc handshake produces one data word, tag 3.
  - Lane i = sign-extended adc_dat[i*(ADC_W+1)+1 +: ADC_W]; the over-range bit is dropped.
  - For 10 samples, bits [127:120] are 0.
  - After wfm_num_bursts words, increment wfm_count.
  - If fill_end was seen at any point during WFM_HDR or DATA (latched pending flag), go → FILL_HDR. Otherwise go → ARMED.
- A trig in WFM_HDR, DATA, FILL_HDR or CSUM is dropped and sets trig_dropped.
- FILL_HDR: emit the fill header, tag 1.
  - [23:0] fill_num
  - [25:24] range
  - [26] 0
  - [49:27] word_count+2, i.e. the total words including this header and the checksum
  - [63:50] wfm_num_bursts
  - [75:64] pre_trig[11:0]
  - [98:76] wfm_count, the final count
  - [102:99] pre_trig[15:12]
  - [121:110] channel_tag
  - [123] 1
  - [127:126] 2'b01
  - All other bits 0.
- CSUM:
  - Emit {4'd4, checksum}, then → IDLE.
  - checksum = XOR of payload[127:0] over every word emitted this fill, before the checksum word itself.
- Counters: word_count counts every word loaded into out_dat. word_count and wfm_count wrap modulo 2^23.

## Timing
- Reset values:
  - State IDLE.
  - out_valid=0, out_dat=0, adc_ready=0, busy=0, trig_dropped=0.
  - All counters and checksum 0.
  - Reset takes effect immediately, including mid-fill. A partially emitted word is discarded.
- Output register advance: the register loads when (!out_valid || out_ready) and a word is available.
- A loaded word holds stable until out_ready is seen.
- Header latency: the header appears on out_dat 1 cycle after the FSM enters WFM_HDR or FILL_HDR and the output slot is free.
- adc_ready = (state==DATA) && (!out_valid || out_ready). It is combinational from out_ready; this is the only combinational path.
- Data latency: data word at cycle t+1 for an adc handshake at cycle t. Full throughput is 1 word/clk with out_ready held high.
- Checksum update: checksum updates in the same cycle a word is loaded, so the CSUM word reflects every preceding word.
- Minimum waveform under no stall: 1 + wfm_num_bursts cycles.

## Structure
- Package adc_burst_pkg contains:
  - Tag constants TAG_FILL=1, TAG_WFM=2, TAG_DATA=3, TAG_CSUM=4.
  - HDR_MARK=2'b01.
  - The state enum.
  - Header-assembly functions.
- Sub-module adc_sample_packer is combinational. It does lane extraction, sign extension and zero padding, parametrised by SAMPLES_PER_BURST, ADC_W and LANE_W.
- Elaboration assertions:
  - SAMPLES_PER_BURST ∈ {8, 10}.
  - LANE_W ≥ ADC_W.
  - SAMPLES_PER_BURST × LANE_W ≤ 128.

## Test plan
- fill_start, 1 trig with wfm_num_bursts=2, samples all 0x7FF, then fill_end → stream tags 2,3,3,1,4.
  - Lanes = 0x07FF.
  - Fill header [49:27] = 5 and [98:76] = 1.
  - Checksum = XOR of the first 4 payloads.
- 3 triggers with wfm_num_bursts=1 → waveform header start addresses 0, 4, 8 and indices 0, 1, 2.
- Sample value 0x800 with over-range bit 1 → lane 0xF800.
- SAMPLES_PER_BURST=10 instance → lane 0xF800 becomes 0x800 (12-bit), and bits [127:120] = 0.
- out_ready held low for 5 cycles mid-DATA → out_dat stable, adc_ready=0, no words lost or duplicated.
- trig during DATA → trig_dropped=1, and no extra header is emitted.
- fill_end during DATA → the current waveform completes, then FILL_HDR.
- rst_n asserted mid-DATA → all outputs 0 immediately.
  - The next fill_start gives wfm_count=0 and checksum restarts at 0.
